// File: rtl/verificador_contador_0_1_2_3_10_13.sv
// Receiving-end checker for the counter sequence 0,1,2,3,10,13: hunts for the
// start, locks after a clean run, then flags and counts deviations while locked.
module verificador_contador_0_1_2_3_10_13 #(
    parameter int LOCK_LEN = 6,
    parameter int MAX_ERR  = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       y,
    input  logic             en,
    output logic             travado,
    output logic             erro,
    output logic             ciclo,
    output logic [3:0]       esperado,
    output logic [CNT_W-1:0] contagem_erros,
    output logic [CNT_W-1:0] contagem_ciclos
);

    localparam logic [3:0] LOCK_LEN_L = 4'(LOCK_LEN);
    localparam logic [2:0] MAX_ERR_L  = 3'(MAX_ERR);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       match_cnt_reg, match_cnt_next;
    logic [2:0]       miss_cnt_reg, miss_cnt_next;
    logic [3:0]       esperado_reg, esperado_next;
    logic             travado_reg, travado_next;
    logic             erro_reg, erro_next;
    logic             ciclo_reg, ciclo_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;

    function automatic logic [3:0] successor(input logic [3:0] v);
        case (v)
            4'd0:    successor = 4'd1;
            4'd1:    successor = 4'd2;
            4'd2:    successor = 4'd3;
            4'd3:    successor = 4'd10;
            4'd10:   successor = 4'd13;
            default: successor = 4'd0;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= HUNT;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            esperado_reg  <= '0;
            travado_reg   <= 1'b0;
            erro_reg      <= 1'b0;
            ciclo_reg     <= 1'b0;
            err_cnt_reg   <= '0;
            cyc_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            esperado_reg  <= esperado_next;
            travado_reg   <= travado_next;
            erro_reg      <= erro_next;
            ciclo_reg     <= ciclo_next;
            err_cnt_reg   <= err_cnt_next;
            cyc_cnt_reg   <= cyc_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        esperado_next  = esperado_reg;
        travado_next   = travado_reg;
        erro_next      = 1'b0;
        ciclo_next     = 1'b0;
        err_cnt_next   = err_cnt_reg;
        cyc_cnt_next   = cyc_cnt_reg;

        if (en) begin
            case (state_reg)
                HUNT: begin
                    if (y == 4'd0) begin
                        match_cnt_next = 4'd1;
                        esperado_next  = 4'd1;
                        if (LOCK_LEN_L == 4'd1) begin
                            state_next   = LOCKED;
                            travado_next = 1'b1;
                        end else begin
                            state_next = TRACK;
                        end
                    end else begin
                        esperado_next = 4'd0;
                    end
                end
                TRACK: begin
                    if (y == esperado_reg) begin
                        match_cnt_next = match_cnt_reg + 4'd1;
                        esperado_next  = successor(esperado_reg);
                        if (match_cnt_reg + 4'd1 == LOCK_LEN_L) begin
                            state_next   = LOCKED;
                            travado_next = 1'b1;
                        end
                    end else if (y == 4'd0) begin
                        // A stray 0 is itself a valid sequence start.
                        match_cnt_next = 4'd1;
                        esperado_next  = 4'd1;
                    end else begin
                        state_next     = HUNT;
                        match_cnt_next = 4'd0;
                        esperado_next  = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: keep stepping through glitches.
                    esperado_next = successor(esperado_reg);
                    if (y == esperado_reg) begin
                        miss_cnt_next = 3'd0;
                        if (y == 4'd13) begin
                            ciclo_next   = 1'b1;
                            cyc_cnt_next = cyc_cnt_reg + 1'b1;
                        end
                    end else begin
                        erro_next     = 1'b1;
                        miss_cnt_next = miss_cnt_reg + 3'd1;
                        if (err_cnt_reg != '1) begin
                            err_cnt_next = err_cnt_reg + 1'b1;
                        end
                        if (miss_cnt_reg + 3'd1 == MAX_ERR_L) begin
                            state_next     = HUNT;
                            travado_next   = 1'b0;
                            esperado_next  = 4'd0;
                            miss_cnt_next  = 3'd0;
                            match_cnt_next = 4'd0;
                        end
                    end
                end
                default: begin
                    state_next     = HUNT;
                    travado_next   = 1'b0;
                    esperado_next  = 4'd0;
                    match_cnt_next = 4'd0;
                    miss_cnt_next  = 3'd0;
                end
            endcase
        end
    end

    assign travado         = travado_reg;
    assign erro            = erro_reg;
    assign ciclo           = ciclo_reg;
    assign esperado        = esperado_reg;
    assign contagem_erros  = err_cnt_reg;
    assign contagem_ciclos = cyc_cnt_reg;

endmodule

// File: tb/tb_verificador_contador_0_1_2_3_10_13.sv
// Bench for the sequence checker: directed scenarios plus randomized traffic,
// compared against an index-based model of the expected sequence.
module tb_verificador_contador_0_1_2_3_10_13;

    localparam int LOCK_LEN = 6;
    localparam int MAX_ERR  = 3;
    localparam int CNT_W    = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       y     = 4'd0;
    logic             en    = 1'b0;
    logic             travado, erro, ciclo;
    logic [3:0]       esperado;
    logic [CNT_W-1:0] contagem_erros, contagem_ciclos;

    int total = 0;
    int bad   = 0;

    verificador_contador_0_1_2_3_10_13 #(
        .LOCK_LEN(LOCK_LEN), .MAX_ERR(MAX_ERR), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .y(y), .en(en),
        .travado(travado), .erro(erro), .ciclo(ciclo), .esperado(esperado),
        .contagem_erros(contagem_erros), .contagem_ciclos(contagem_ciclos)
    );

    always #5 clock = ~clock;

    // Reference model: position in the 6-entry sequence plus run/miss tallies.
    int seq [6] = '{0, 1, 2, 3, 10, 13};
    int m_mode, m_idx, m_run, m_miss, m_errs, m_cycs;
    bit m_erro, m_ciclo;

    logic [2*CNT_W+6:0] obs_vec;
    assign obs_vec = {travado, erro, ciclo, esperado, contagem_erros, contagem_ciclos};

    function automatic logic [2*CNT_W+6:0] model_vec();
        return {(m_mode == 2), m_erro, m_ciclo, 4'(seq[m_idx]), CNT_W'(m_errs), CNT_W'(m_cycs)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_run = 0; m_miss = 0;
        m_errs = 0; m_cycs = 0; m_erro = 0; m_ciclo = 0;
    endtask

    task automatic model_update(input int yv, input bit env);
        m_erro = 0;
        m_ciclo = 0;
        if (!env) return;
        case (m_mode)
            0: if (yv == 0) begin
                m_idx = 1; m_run = 1;
                m_mode = (LOCK_LEN == 1) ? 2 : 1;
            end
            1: if (yv == seq[m_idx]) begin
                m_run++;
                m_idx = (m_idx + 1) % 6;
                if (m_run == LOCK_LEN) m_mode = 2;
            end else if (yv == 0) begin
                m_run = 1; m_idx = 1;
            end else begin
                m_mode = 0; m_run = 0; m_idx = 0;
            end
            default: begin
                if (yv == seq[m_idx]) begin
                    m_miss = 0;
                    if (yv == 13) begin
                        m_ciclo = 1;
                        m_cycs = (m_cycs + 1) % (1 << CNT_W);
                    end
                end else begin
                    m_erro = 1;
                    m_miss++;
                    if (m_errs < (1 << CNT_W) - 1) m_errs++;
                end
                m_idx = (m_idx + 1) % 6;
                if (m_miss == MAX_ERR) begin
                    m_mode = 0; m_idx = 0; m_miss = 0; m_run = 0;
                end
            end
        endcase
    endtask

    task automatic step(input logic [3:0] yv, input logic env);
        @(negedge clock);
        y  = yv;
        en = env;
        @(posedge clock);
        model_update(int'(yv), env);
        #1;
        $display("t=%0t y=%0d en=%0b trav=%0b erro=%0b ciclo=%0b esp=%0d nerr=%0d ncyc=%0d",
                 $time, yv, env, travado, erro, ciclo, esperado, contagem_erros, contagem_ciclos);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en = 1'b0;
        repeat (3) @(posedge clock);
        model_reset();
        #1;
        total++;
        if (obs_vec !== model_vec()) begin
            bad++;
            $display("FAIL reset_state: got %h expected %h", obs_vec, model_vec());
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_lock();
        logic [3:0] s [12] = '{0, 1, 2, 3, 10, 13, 0, 1, 2, 3, 10, 13};
        for (int i = 0; i < 12; i++) begin
            step(s[i], 1'b1);
            total++;
            if (obs_vec !== model_vec()) begin
                bad++;
                $display("FAIL lock[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
            if (i == 5) begin
                total++;
                if (travado !== 1'b1 || esperado !== 4'd0 || erro !== 1'b0) begin
                    bad++;
                    $display("FAIL lock_after_6: got trav=%b esp=%0d erro=%b expected 1 0 0",
                             travado, esperado, erro);
                end
            end
        end
        total++;
        if (ciclo !== 1'b1 || contagem_ciclos !== 8'd1) begin
            bad++;
            $display("FAIL first_ciclo: got ciclo=%b ncyc=%0d expected 1 1", ciclo, contagem_ciclos);
        end
    endtask

    task automatic test_isolated_error();
        logic [3:0] s [6] = '{0, 1, 7, 3, 10, 13};
        for (int i = 0; i < 6; i++) begin
            step(s[i], 1'b1);
            total++;
            if (obs_vec !== model_vec()) begin
                bad++;
                $display("FAIL isolated[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
            if (i == 2) begin
                total++;
                if (erro !== 1'b1 || contagem_erros !== 8'd1 || travado !== 1'b1) begin
                    bad++;
                    $display("FAIL isolated_erro: got erro=%b nerr=%0d trav=%b expected 1 1 1",
                             erro, contagem_erros, travado);
                end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        logic [3:0] s [9] = '{0, 1, 2, 3, 10, 13, 5, 5, 5};
        test_reset();
        for (int i = 0; i < 9; i++) begin
            step(s[i], 1'b1);
            total++;
            if (obs_vec !== model_vec()) begin
                bad++;
                $display("FAIL loss[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
        end
        total++;
        if (contagem_erros !== 8'd3 || travado !== 1'b0 || esperado !== 4'd0 || erro !== 1'b1) begin
            bad++;
            $display("FAIL loss_final: got nerr=%0d trav=%b esp=%0d erro=%b expected 3 0 0 1",
                     contagem_erros, travado, esperado, erro);
        end
    endtask

    task automatic test_resync();
        logic [3:0] s [11] = '{3, 10, 0, 1, 2, 0, 1, 2, 3, 10, 13};
        for (int i = 0; i < 11; i++) begin
            step(s[i], 1'b1);
            total++;
            if (obs_vec !== model_vec()) begin
                bad++;
                $display("FAIL resync[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
            if (i == 5) begin
                total++;
                if (esperado !== 4'd1 || travado !== 1'b0) begin
                    bad++;
                    $display("FAIL resync_restart: got esp=%0d trav=%b expected 1 0", esperado, travado);
                end
            end
        end
        total++;
        if (travado !== 1'b1 || contagem_erros !== 8'd3) begin
            bad++;
            $display("FAIL resync_lock: got trav=%b nerr=%0d expected 1 3", travado, contagem_erros);
        end
    endtask

    task automatic test_en_gap();
        logic [3:0] s [10] = '{0, 1, 2, 0, 0, 0, 0, 3, 10, 13};
        logic       e [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            step(e[i] ? s[i] : 4'($urandom_range(0, 15)), e[i]);
            total++;
            if (obs_vec !== model_vec()) begin
                bad++;
                $display("FAIL en_gap[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
            if (i == 6) begin
                total++;
                if (esperado !== 4'd3 || travado !== 1'b1 || erro !== 1'b0 || ciclo !== 1'b0) begin
                    bad++;
                    $display("FAIL en_gap_hold: got esp=%0d trav=%b erro=%b ciclo=%b expected 3 1 0 0",
                             esperado, travado, erro, ciclo);
                end
            end
        end
    endtask

    task automatic test_saturation_async_reset();
        logic [3:0] s [6] = '{0, 1, 2, 3, 10, 13};
        int n = 0;
        test_reset();
        for (int i = 0; i < 6; i++) step(s[i], 1'b1);
        // Alternate wrong/right samples so lock holds while errors accumulate.
        while (m_errs < 254 || n < 2) begin
            if (m_errs >= 254) n++;
            step(4'((seq[m_idx] + $urandom_range(1, 15)) % 16), 1'b1);
            total++;
            if (obs_vec !== model_vec()) begin
                bad++;
                $display("FAIL sat_err[%0d]: got %h expected %h", m_errs, obs_vec, model_vec());
            end
            step(4'(seq[m_idx]), 1'b1);
        end
        total++;
        if (contagem_erros !== 8'd255 || travado !== 1'b1) begin
            bad++;
            $display("FAIL saturation: got nerr=%0d trav=%b expected 255 1", contagem_erros, travado);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs_vec !== model_vec()) begin
            bad++;
            $display("FAIL async_reset: got %h expected %h", obs_vec, model_vec());
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] yv;
        logic       ev;
        for (int i = 0; i < 400; i++) begin
            ev = ($urandom_range(0, 9) != 0);
            yv = ($urandom_range(0, 5) != 0) ? 4'(seq[m_idx]) : 4'($urandom_range(0, 15));
            step(yv, ev);
            total++;
            if (obs_vec !== model_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_isolated_error();
        test_loss_of_lock();
        test_resync();
        test_en_gap();
        test_saturation_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
